// File: rtl/counter_bist_checker.sv
// -----------------------------------------------------------------------------
// counter_bist_checker
//
// On-fabric self-test for the arithmetic counter benchmark. A 16-bit Fibonacci
// LFSR produces reset/enable stimulus for the mapped counter DUT, a golden
// counter follows the same stimulus on the same edges, and the DUT count is
// compared every cycle. Mismatches are counted (saturating) and the differing
// bit positions are accumulated into a sticky mask.
//
// Optional feature, enabled by defining BIST_FIRST_FAIL_CAPTURE_EN:
//   adds fail_cycle / fail_expected / fail_actual, holding the cycle index,
//   golden value and DUT value of the first mismatching compare of a test.
//
// Control protocol: start is a single-cycle request that is only accepted in
// IDLE or DONE (ignored while busy). busy is high while the test runs; done
// and pass rise together, and pass/err_count/err_mask are valid whenever done
// is high, holding until the next accepted start.
//
// The FSM state is exported on dbg_state (0=IDLE, 1=SEED, 2=RUN, 3=DONE).
// -----------------------------------------------------------------------------
module counter_bist_checker #(
    parameter int          WIDTH      = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          RUN_CYCLES = 10,
    parameter int          ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 dut_reset,
    output logic                 dut_enable,
    input  logic [WIDTH-1:0]     dut_count,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     err_mask,
    output logic [1:0]           dbg_state
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [7:0]           fail_cycle,
    output logic [WIDTH-1:0]     fail_expected,
    output logic [WIDTH-1:0]     fail_actual
`endif
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // The cycle counter also reaches RUN_CYCLES during the first DONE cycle,
    // and is at least 8 bits so the captured fail cycle is a plain slice.
    localparam int CNT_W = ($clog2(RUN_CYCLES + 1) > 8) ? $clog2(RUN_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   dut_reset_q, dut_reset_d;
    logic                   dut_enable_q, dut_enable_d;
    logic [WIDTH-1:0]       golden_q, golden_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [ERR_WIDTH-1:0]   err_count_q, err_count_d;
    logic [WIDTH-1:0]       err_mask_q, err_mask_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic                   final_q, final_d;   // first DONE cycle: last compare

`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    logic                   fail_seen_q, fail_seen_d;
    logic [7:0]             fail_cycle_q, fail_cycle_d;
    logic [WIDTH-1:0]       fail_expected_q, fail_expected_d;
    logic [WIDTH-1:0]       fail_actual_q, fail_actual_d;
`endif

    logic                   feedback;
    logic [WIDTH-1:0]       diff;
    logic                   cmp_en;
    logic                   mismatch;

    // Next-state logic: FSM, stimulus generation, golden model and compare.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        dut_reset_d  = dut_reset_q;
        dut_enable_d = dut_enable_q;
        golden_d     = golden_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        err_mask_d   = err_mask_q;
        cycle_d      = cycle_q;
        final_d      = 1'b0;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        fail_seen_d     = fail_seen_q;
        fail_cycle_d    = fail_cycle_q;
        fail_expected_d = fail_expected_q;
        fail_actual_d   = fail_actual_q;
`endif

        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

        // The golden counter samples the registered stimulus on the same edge
        // as the DUT; reset wins over enable.
        if (dut_reset_q) begin
            golden_d = '0;
        end else if (dut_enable_q) begin
            golden_d = golden_q + WIDTH'(1);
        end

        // The first RUN cycle still shows the DUT count from before the SEED
        // reset reached it, so compares start on the second RUN cycle. The
        // first DONE cycle checks the result of the last compared stimulus.
        diff     = dut_count ^ golden_q;
        cmp_en   = ((state_q == S_RUN) && (cycle_q != '0)) ||
                   ((state_q == S_DONE) && final_q);
        mismatch = cmp_en && (diff != '0);

        if (cmp_en) begin
            err_mask_d = err_mask_q | diff;
            if (mismatch && (err_count_q != '1)) begin
                err_count_d = err_count_q + ERR_WIDTH'(1);
            end
        end

`ifdef BIST_FIRST_FAIL_CAPTURE_EN
        if (mismatch && !fail_seen_q) begin
            fail_seen_d     = 1'b1;
            fail_cycle_d    = cycle_q[7:0];
            fail_expected_d = golden_q;
            fail_actual_d   = dut_count;
        end
`endif

        case (state_q)
            S_IDLE: begin
                dut_reset_d  = 1'b1;
                dut_enable_d = 1'b0;
                if (start) begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                lfsr_d       = SEED_EFF;
                cycle_d      = '0;
                golden_d     = '0;
                dut_reset_d  = 1'b1;
                dut_enable_d = 1'b0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                dut_reset_d  = lfsr_q[0];
                dut_enable_d = lfsr_q[1];
                lfsr_d       = {lfsr_q[14:0], feedback};
                cycle_d      = cycle_q + CNT_W'(1);
                if (cycle_q == LAST_RUN) begin
                    state_d = S_DONE;
                    final_d = 1'b1;
                end
            end
            S_DONE: begin
                dut_reset_d  = 1'b1;
                dut_enable_d = 1'b0;
                if (final_q) begin
                    done_d = 1'b1;
                    pass_d = (err_count_d == '0);
                end
                if (start) begin
                    state_d = S_SEED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accepting a start discards the previous results immediately.
        if ((state_d == S_SEED) && (state_q != S_SEED)) begin
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_count_d = '0;
            err_mask_d  = '0;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
            fail_seen_d     = 1'b0;
            fail_cycle_d    = '0;
            fail_expected_d = '0;
            fail_actual_d   = '0;
`endif
        end

        busy_d = (state_d == S_SEED) || (state_d == S_RUN);
    end

    // All state registers; asynchronous reset returns to IDLE with the DUT
    // held in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED_EFF;
            dut_reset_q  <= 1'b1;
            dut_enable_q <= 1'b0;
            golden_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            err_mask_q   <= '0;
            cycle_q      <= '0;
            final_q      <= 1'b0;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
            fail_seen_q     <= 1'b0;
            fail_cycle_q    <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            dut_reset_q  <= dut_reset_d;
            dut_enable_q <= dut_enable_d;
            golden_q     <= golden_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            err_mask_q   <= err_mask_d;
            cycle_q      <= cycle_d;
            final_q      <= final_d;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
            fail_seen_q     <= fail_seen_d;
            fail_cycle_q    <= fail_cycle_d;
            fail_expected_q <= fail_expected_d;
            fail_actual_q   <= fail_actual_d;
`endif
        end
    end

    assign dut_reset  = dut_reset_q;
    assign dut_enable = dut_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign err_mask   = err_mask_q;
    assign dbg_state  = state_q;

`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    assign fail_cycle    = fail_cycle_q;
    assign fail_expected = fail_expected_q;
    assign fail_actual   = fail_actual_q;
`endif

endmodule

// File: tb/tb_counter_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_bist_checker
//
// Three checker instances, each driving a behavioural reference counter whose
// output can be corrupted in several ways before it returns as dut_count:
//   0: RUN_CYCLES=10,  ERR_WIDTH=8  (clean, start ignored, mid-run reset)
//   1: RUN_CYCLES=200, ERR_WIDTH=8  (bit 3 / bit 0 stuck-at-0)
//   2: RUN_CYCLES=10,  ERR_WIDTH=2  (inverted count, saturation)
// Expected stimulus and results come from an LFSR/counter model in the bench.
// -----------------------------------------------------------------------------
module tb_counter_bist_checker;
  localparam int W     = 16;
  localparam int RES_W = 1 + 8 + W;
  localparam int RC[3] = '{10, 200, 10};
  localparam int EW[3] = '{8, 8, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         start      [3];
  logic         dut_reset  [3];
  logic         dut_enable [3];
  logic         busy       [3];
  logic         done       [3];
  logic         pass       [3];
  logic [7:0]   err_count  [3];
  logic [W-1:0] err_mask   [3];
  logic [1:0]   dbg_state  [3];
  int           fault_mode [3];
  logic         fault_on   [3];
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
  logic [7:0]   fail_cycle    [3];
  logic [W-1:0] fail_expected [3];
  logic [W-1:0] fail_actual   [3];
`endif

  function automatic logic [W-1:0] fault_fn(input int mode, input logic [W-1:0] v);
    case (mode)
      1:       return v & ~16'h0008;
      2:       return v & ~16'h0001;
      3:       return ~v;
      4:       return v | 16'h0001;
      default: return v;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [W-1:0]     ref_q;
    logic [W-1:0]     cnt;
    logic [EW[g]-1:0] ec;

    always_ff @(posedge clk) begin
      if (dut_reset[g]) ref_q <= '0;
      else if (dut_enable[g]) ref_q <= ref_q + 16'd1;
    end
    assign cnt = fault_on[g] ? fault_fn(fault_mode[g], ref_q) : ref_q;
    assign err_count[g] = 8'(ec);

    counter_bist_checker #(
      .WIDTH(W), .SEED(16'hACE1), .RUN_CYCLES(RC[g]), .ERR_WIDTH(EW[g])
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[g]),
      .dut_reset(dut_reset[g]), .dut_enable(dut_enable[g]), .dut_count(cnt),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_count(ec), .err_mask(err_mask[g]), .dbg_state(dbg_state[g])
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
      , .fail_cycle(fail_cycle[g]), .fail_expected(fail_expected[g]),
      .fail_actual(fail_actual[g])
`endif
    );
  end

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [1:0]       stim_q[$];
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
  logic [8+2*W-1:0] cap_q[$];
`endif
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [W-1:0] step(input logic [W-1:0] v, input logic [1:0] s);
    if (s[1]) return '0;
    if (s[0]) return v + 16'd1;
    return v;
  endfunction

  task automatic check_reset_state(input int i);
    chk("rst_state", 32'(dbg_state[i]), 32'd0);
    chk("rst_dut_reset", 32'(dut_reset[i]), 32'd1);
    chk("rst_dut_enable", 32'(dut_enable[i]), 32'd0);
    chk("rst_busy", 32'(busy[i]), 32'd0);
    chk("rst_done", 32'(done[i]), 32'd0);
    chk("rst_pass", 32'(pass[i]), 32'd0);
    chk("rst_err_count", 32'(err_count[i]), 32'd0);
    chk("rst_err_mask", 32'(err_mask[i]), 32'd0);
  endtask

  // ---------------- driver: one complete test on instance i ----------------
  task automatic run_test(input int i, input int runs, input int errw,
                          input int mode, input int act, input bit poke);
    logic [15:0]      lf;
    logic [1:0]       s[$];
    logic [W-1:0]     v, fv, d, mask, f_exp, f_act;
    logic [RES_W-1:0] res;
    logic [1:0]       st;
    int               ec, sat, first_j;

    // Model: stimulus sequence, then the values seen at each compare point.
    lf = 16'hACE1;
    for (int k = 0; k < runs; k++) begin
      s.push_back({lf[0], lf[1]});
      stim_q.push_back({lf[0], lf[1]});
      lf = lfsr_next(lf);
    end
    v = '0; mask = '0; ec = 0; first_j = -1; f_exp = '0; f_act = '0;
    sat = (1 << errw) - 1;
    for (int j = 1; j <= runs; j++) begin
      if (j >= 2) v = step(v, s[j-2]);
      fv = (j >= act) ? fault_fn(mode, v) : v;
      d  = fv ^ v;
      if (d != '0) begin
        if (ec < sat) ec++;
        if (first_j < 0) begin
          first_j = j; f_exp = v; f_act = fv;
        end
      end
      mask |= d;
    end
    exp_q.push_back({1'(ec == 0), 8'(ec), mask});
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    cap_q.push_back({(first_j < 0) ? 8'd0 : 8'(first_j), f_exp, f_act});
`endif

    fault_mode[i] = mode;
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    chk("seed_busy", 32'(busy[i]), 32'd1);
    chk("seed_state", 32'(dbg_state[i]), 32'd1);
    chk("seed_done", 32'(done[i]), 32'd0);

    for (int k = 1; k <= runs + 1; k++) begin
      @(negedge clk);
      if (k == act + 1) fault_on[i] = 1'b1;
      start[i] = (poke && (k == 3)) ? 1'b1 : 1'b0;
      if (k == 1) begin
        chk("run0_dut_reset", 32'(dut_reset[i]), 32'd1);
        chk("run0_dut_enable", 32'(dut_enable[i]), 32'd0);
      end else begin
        st = stim_q.pop_front();
        chk("stimulus", 32'({dut_reset[i], dut_enable[i]}), 32'(st));
      end
      if (k <= runs) begin
        chk("run_busy", 32'(busy[i]), 32'd1);
        chk("run_state", 32'(dbg_state[i]), 32'd2);
      end else begin
        chk("final_busy", 32'(busy[i]), 32'd0);
        chk("final_done", 32'(done[i]), 32'd0);
        chk("final_state", 32'(dbg_state[i]), 32'd3);
      end
    end
    start[i] = 1'b0;

    @(negedge clk);
    res = exp_q.pop_front();
    chk("done", 32'(done[i]), 32'd1);
    chk("done_state", 32'(dbg_state[i]), 32'd3);
    chk("pass", 32'(pass[i]), 32'(res[RES_W-1]));
    chk("err_count", 32'(err_count[i]), 32'(res[W+7:W]));
    chk("err_mask", 32'(err_mask[i]), 32'(res[W-1:0]));
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    begin
      logic [8+2*W-1:0] cap;
      cap = cap_q.pop_front();
      chk("fail_cycle", 32'(fail_cycle[i]), 32'(cap[8+2*W-1:2*W]));
      chk("fail_expected", 32'(fail_expected[i]), 32'(cap[2*W-1:W]));
      chk("fail_actual", 32'(fail_actual[i]), 32'(cap[W-1:0]));
    end
`endif
    @(negedge clk);
    chk("hold_done", 32'(done[i]), 32'd1);
    chk("hold_err_count", 32'(err_count[i]), 32'(res[W+7:W]));
    fault_on[i] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b1; fault_on[i] = 1'b0; fault_mode[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_state(i);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("idle_state", 32'(dbg_state[i]), 32'd0);

    run_test(0, 10, 8, 0, 0, 1'b0);   // exact counter
    run_test(0, 10, 8, 0, 0, 1'b1);   // start pulsed mid-run is ignored
    run_test(1, 200, 8, 1, 0, 1'b0);  // bit 3 stuck-at-0
    run_test(1, 200, 8, 2, 0, 1'b0);  // bit 0 stuck-at-0
    run_test(2, 10, 2, 3, 0, 1'b0);   // inverted count, 2-bit saturation

    // Reset in RUN cycle 5, then a clean rerun must repeat the same sequence.
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_state", 32'(dbg_state[0]), 32'd2);
    reset = 1'b1;
    #1;
    check_reset_state(0);
    @(negedge clk); reset = 1'b0;
    run_test(0, 10, 8, 0, 0, 1'b0);

`ifdef BIST_FIRST_FAIL_CAPTURE_EN
    run_test(0, 10, 8, 4, 4, 1'b0);   // bit 0 forced high from RUN cycle 4
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
